switch_matrix_ctrl: RTL and testbench
=====================================

// Module: switch_matrix_ctrl
// PURPOSE
// - Parametrised successor to the fixed six-chip crosspoint switch group; drives N_CHIP analog crosspoint chips
//   (4-bit AX, 3-bit AY, DATA, active-low STROBE) over one shared address/data bus plus per-chip active-low CS/RESET.
// - Sits on the logic_control device bus (cs/rdy/op/addr/data_in), decoding one command per cs pulse.
// - New vs. predecessor: parametrised chip count and timing, multi-chip broadcast by mask, busy/err status.
// PARAMETERS
// - N_CHIP     6  number of switch chips; legal range 1..16
// - SETUP_CYC  2  clk cycles CS/AX/AY/DATA stable before STROBE falls; must be >=1
// - STROBE_CYC 4  clk cycles STROBE held low; must be >=1
// - HOLD_CYC   2  clk cycles CS/AX/AY/DATA held after STROBE rises; must be >=1
// - RESET_CYC  8  clk cycles RESET held low for the RESET op; must be >=1
// PORTS
// - clk     in   1       system clock; single clock domain
// - rst     in   1       synchronous, active-high reset
// - cs      in   1       one-cycle command strobe from logic_control
// - op      in   4       opcode; sampled when cs=1
// - addr    in   8       [3:0]=AX, [6:4]=AY, [7] ignored
// - data_in in   16      [3:0]=chip index (single ops) or [N_CHIP-1:0]=chip mask (broadcast/reset ops)
// - rdy     out  1       one-cycle pulse when the command completes, including rejected commands
// - busy    out  1       high from the cycle after accepted cs until the rdy cycle inclusive
// - err     out  1       sticky; set by a rejected command; cleared by rst or next accepted valid command
// - CS_N    out  N_CHIP  per-chip chip select, active low
// - RESET_N out  N_CHIP  per-chip reset, active low
// - AX      out  4       shared X address
// - AY      out  3       shared Y address
// - STROBE  out  1       shared latch strobe, active low
// - DATA    out  1       shared data; 1=close switch, 0=open switch
// BEHAVIOUR
// - Reset values: CS_N=all 1, RESET_N=all 1, STROBE=1, DATA=0, AX=0, AY=0, rdy=0, busy=0, err=0.
// - Opcodes: 1=CONNECT, 2=DISCONNECT (single chip), 3=RESET (mask), 4=BCAST_CONNECT, 5=BCAST_DISCONNECT (mask).
//   0 and 6..15 are rejected. A rejected command is illegal op, chip index >=N_CHIP, or effective mask==0.
// - FSM: IDLE -> SETUP -> STRB -> HOLD -> DONE -> IDLE for write ops; IDLE -> RSTP -> DONE -> IDLE for RESET.
// - IDLE with cs=1: latch op/addr/data_in; drive AX/AY/DATA and selected CS_N low on the next edge.
//   Effective mask = data_in[N_CHIP-1:0]; mask bits >=N_CHIP are ignored.
// - Write timing after cs at cycle 0: CS_N/AX/AY/DATA valid cycles 1..SETUP+STROBE+HOLD.
//   STROBE is low for cycles SETUP+1..SETUP+STROBE. rdy is high at cycle SETUP+STROBE+HOLD+1, with CS_N all 1 in the same cycle.
//   With defaults, rdy is at cycle 9.
// - RESET timing: RESET_N of masked chips is low for cycles 1..RESET_CYC; CS_N stays high; rdy at cycle RESET_CYC+1.
// - Rejected command: no pin activity; rdy and err at cycle 1; busy stays 0.
// - cs while busy or in DONE: ignored; no queueing, no err.
// - AX/AY/DATA keep their last driven value after a command (no return to 0); they change only on an accepted write op.
// - rst mid-operation: all outputs take reset values on the next edge. An early STROBE rise may latch a switch;
//   switch state is then undefined and the host must issue RESET.
// - rst and cs in the same cycle: rst wins; the command is dropped.
// - Counters: one down-counter, width clog2(max(SETUP,STROBE,HOLD,RESET_CYC)+1); reloaded on each state entry;
//   transition occurs when count==1.
// STRUCTURE
// - Header switch_defs.vh: opcode localparams and FSM state encodings; shared with logic_control and the bench.
// - Sub-module phase_timer: loadable down-counter with a done flag; the FSM owns the sequencing.
// - Elaboration-time check: N_CHIP outside 1..16 or any timing parameter of 0 is a fatal error.
// TESTING
// - CONNECT: op=1, addr=8'h35, data_in=2 -> CS_N=6'b111011, AX=5, AY=3, DATA=1 cycles 1-8; STROBE low cycles 3-6; rdy at cycle 9.
// - BCAST_DISCONNECT: op=5, data_in=16'h0029 -> CS_N=6'b010110 during the command; DATA=0; single STROBE pulse; rdy at cycle 9.
// - RESET: op=3, data_in=16'h003F -> RESET_N=0 cycles 1-8, CS_N all 1, STROBE stays 1; rdy at cycle 9.
// - Rejects: op=1 with data_in=6, op=4 with data_in=16'h0040, op=7 -> no pin change; rdy and err at cycle 1;
//   a following valid op clears err.
// - Busy/reset: cs during busy -> ignored and rdy count unchanged; rst asserted during STRB -> next edge all outputs at reset values, FSM in IDLE.
// - Param sweep: N_CHIP=1 and N_CHIP=16 with SETUP=STROBE=HOLD=1 -> rdy at cycle 4; mask bit 15 reaches CS_N[15].

Source files
------------

// File: rtl/switch_matrix_ctrl_pkg.sv
// Shared definitions for the crosspoint switch controller: opcodes, FSM states, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package switch_matrix_ctrl_pkg;

    localparam logic [3:0] OP_CONNECT          = 4'd1;
    localparam logic [3:0] OP_DISCONNECT       = 4'd2;
    localparam logic [3:0] OP_RESET            = 4'd3;
    localparam logic [3:0] OP_BCAST_CONNECT    = 4'd4;
    localparam logic [3:0] OP_BCAST_DISCONNECT = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_STRB  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RSTP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Largest of the four phase lengths; sizes the shared phase counter.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/switch_matrix_ctrl_phase_timer.sv
// Loadable down-counter; done is high while the count sits at 1 (last cycle of a phase).
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; counts every cycle until it reaches zero and then stays there.
// Ports: clk, rst (sync, active high), load/load_val (reload), done (phase ends this cycle).
module switch_matrix_ctrl_phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == CW'(1));

endmodule

// File: rtl/switch_matrix_ctrl.sv
// Drives N_CHIP crosspoint chips over a shared AX/AY/DATA/STROBE bus with per-chip CS_N/RESET_N.
// Latency: rdy at SETUP+STROBE+HOLD+1 cycles after cs for writes, RESET_CYC+1 for reset, 1 for rejects.
// Backpressure: none; cs while busy or finishing is dropped (no queue), host waits for rdy.
// Ports: clk, rst (sync, active high); cs/op/addr/data_in command in; rdy/busy/err status out;
//        CS_N/RESET_N per chip (active low); AX/AY/DATA/STROBE shared chip bus (STROBE active low).
module switch_matrix_ctrl
    import switch_matrix_ctrl_pkg::*;
#(
    parameter int N_CHIP     = 6,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int RESET_CYC  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [3:0]        op,
    input  logic [7:0]        addr,
    input  logic [15:0]       data_in,
    output logic              rdy,
    output logic              busy,
    output logic              err,
    output logic [N_CHIP-1:0] CS_N,
    output logic [N_CHIP-1:0] RESET_N,
    output logic [3:0]        AX,
    output logic [2:0]        AY,
    output logic              STROBE,
    output logic              DATA
);

    localparam int CW = $clog2(max_of4(SETUP_CYC, STROBE_CYC, HOLD_CYC, RESET_CYC) + 1);

    generate
        if (N_CHIP < 1 || N_CHIP > 16 || SETUP_CYC < 1 || STROBE_CYC < 1 ||
            HOLD_CYC < 1 || RESET_CYC < 1) begin : g_bad_param
            $fatal(1, "switch_matrix_ctrl: N_CHIP must be 1..16 and all phase lengths >= 1");
        end
    endgenerate

    state_t            state;
    logic [15:0]       one_hot;
    logic [N_CHIP-1:0] cmd_mask;
    logic              cmd_legal;
    logic              cmd_ok;
    logic              cmd_write;
    logic              cmd_close;
    logic              tmr_load;
    logic [CW-1:0]     tmr_val;
    logic              tmr_done;
    logic              unused_bits;

    // addr[7] and mask bits beyond N_CHIP are don't-care by definition.
    assign unused_bits = ^{addr[7], data_in};

    // Command decode. A single-chip index >= N_CHIP lands outside cmd_mask, so
    // "bad index" and "empty mask" both reduce to cmd_mask == 0.
    always_comb begin
        one_hot   = 16'h0001 << data_in[3:0];
        cmd_mask  = '0;
        cmd_legal = 1'b0;
        cmd_write = 1'b0;
        cmd_close = 1'b0;
        case (op)
            OP_CONNECT, OP_DISCONNECT: begin
                cmd_mask  = one_hot[N_CHIP-1:0];
                cmd_legal = 1'b1;
                cmd_write = 1'b1;
                cmd_close = (op == OP_CONNECT);
            end
            OP_BCAST_CONNECT, OP_BCAST_DISCONNECT: begin
                cmd_mask  = data_in[N_CHIP-1:0];
                cmd_legal = 1'b1;
                cmd_write = 1'b1;
                cmd_close = (op == OP_BCAST_CONNECT);
            end
            OP_RESET: begin
                cmd_mask  = data_in[N_CHIP-1:0];
                cmd_legal = 1'b1;
            end
            default: ;
        endcase
        cmd_ok = cmd_legal && (|cmd_mask);
    end

    // Timer reload on every phase entry; HOLD and RSTP are the last timed phases,
    // so nothing reloads when they end.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                if (cs && cmd_ok) begin
                    tmr_load = 1'b1;
                    tmr_val  = cmd_write ? CW'(SETUP_CYC) : CW'(RESET_CYC);
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(STROBE_CYC);
                end
            end
            ST_STRB: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(HOLD_CYC);
                end
            end
            default: ;
        endcase
    end

    switch_matrix_ctrl_phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            CS_N    <= '1;
            RESET_N <= '1;
            AX      <= '0;
            AY      <= '0;
            STROBE  <= 1'b1;
            DATA    <= 1'b0;
            rdy     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            rdy <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs) begin
                        if (!cmd_ok) begin
                            // Rejected: report immediately, touch no chip pins.
                            err   <= 1'b1;
                            rdy   <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            err  <= 1'b0;
                            busy <= 1'b1;
                            if (cmd_write) begin
                                CS_N  <= ~cmd_mask;
                                AX    <= addr[3:0];
                                AY    <= addr[6:4];
                                DATA  <= cmd_close;
                                state <= ST_SETUP;
                            end else begin
                                RESET_N <= ~cmd_mask;
                                state   <= ST_RSTP;
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        STROBE <= 1'b0;
                        state  <= ST_STRB;
                    end
                end
                ST_STRB: begin
                    if (tmr_done) begin
                        STROBE <= 1'b1;
                        state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        CS_N  <= '1;
                        rdy   <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_RSTP: begin
                    if (tmr_done) begin
                        RESET_N <= '1;
                        rdy     <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // busy covers the rdy cycle, drops here; cs in this cycle is ignored.
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_matrix_ctrl.sv
module tb_switch_matrix_ctrl;
    import switch_matrix_ctrl_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cs, cs2;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [15:0] data_in;

    logic        rdy, busy, err, STROBE, DATA;
    logic [5:0]  CS_N, RESET_N;
    logic [3:0]  AX;
    logic [2:0]  AY;

    logic        rdy1, busy1, err1, STROBE1, DATA1;
    logic [0:0]  CS_N1, RESET_N1;
    logic [3:0]  AX1;
    logic [2:0]  AY1;

    logic        rdy16, busy16, err16, STROBE16, DATA16;
    logic [15:0] CS_N16, RESET_N16;
    logic [3:0]  AX16;
    logic [2:0]  AY16;

    switch_matrix_ctrl dut (
        .clk(clk), .rst(rst), .cs(cs), .op(op), .addr(addr), .data_in(data_in),
        .rdy(rdy), .busy(busy), .err(err), .CS_N(CS_N), .RESET_N(RESET_N),
        .AX(AX), .AY(AY), .STROBE(STROBE), .DATA(DATA)
    );

    switch_matrix_ctrl #(.N_CHIP(1), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_n1 (
        .clk(clk), .rst(rst), .cs(cs2), .op(op), .addr(addr), .data_in(data_in),
        .rdy(rdy1), .busy(busy1), .err(err1), .CS_N(CS_N1), .RESET_N(RESET_N1),
        .AX(AX1), .AY(AY1), .STROBE(STROBE1), .DATA(DATA1)
    );

    switch_matrix_ctrl #(.N_CHIP(16), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_n16 (
        .clk(clk), .rst(rst), .cs(cs2), .op(op), .addr(addr), .data_in(data_in),
        .rdy(rdy16), .busy(busy16), .err(err16), .CS_N(CS_N16), .RESET_N(RESET_N16),
        .AX(AX16), .AY(AY16), .STROBE(STROBE16), .DATA(DATA16)
    );

    typedef struct {
        int         issue;
        int         lat;
        logic       err;
        int         busy_n;
        logic [5:0] cs_low;
        int         cs_n;
        logic [5:0] rst_low;
        int         rst_n;
        int         strb_first;
        int         strb_len;
        logic [3:0] ax;
        logic [2:0] ay;
        logic       data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_exp = 0;
    int   n_rdy = 0;
    int   n_extra = 0;

    logic [3:0] last_ax;
    logic [2:0] last_ay;
    logic       last_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Hand-computed default timing: SETUP=2, STROBE=4, HOLD=2, RESET_CYC=8.
    function automatic exp_t exp_write(input logic [5:0] m, input logic [3:0] x,
                                       input logic [2:0] y, input logic d);
        exp_t e;
        e.issue = 0; e.lat = 9; e.err = 1'b0; e.busy_n = 9;
        e.cs_low = m; e.cs_n = 8; e.rst_low = '0; e.rst_n = 0;
        e.strb_first = 3; e.strb_len = 4;
        e.ax = x; e.ay = y; e.data = d;
        last_ax = x; last_ay = y; last_data = d;
        return e;
    endfunction

    function automatic exp_t exp_reset(input logic [5:0] m);
        exp_t e;
        e.issue = 0; e.lat = 9; e.err = 1'b0; e.busy_n = 9;
        e.cs_low = '0; e.cs_n = 0; e.rst_low = m; e.rst_n = 8;
        e.strb_first = 0; e.strb_len = 0;
        e.ax = last_ax; e.ay = last_ay; e.data = last_data;
        return e;
    endfunction

    function automatic exp_t exp_reject();
        exp_t e;
        e.issue = 0; e.lat = 1; e.err = 1'b1; e.busy_n = 0;
        e.cs_low = '0; e.cs_n = 0; e.rst_low = '0; e.rst_n = 0;
        e.strb_first = 0; e.strb_len = 0;
        e.ax = last_ax; e.ay = last_ay; e.data = last_data;
        return e;
    endfunction

    task automatic send(input logic [3:0] o, input logic [7:0] a, input logic [15:0] d,
                        input logic push, input exp_t e);
        exp_t t;
        @(posedge clk); #1;
        cs = 1'b1; op = o; addr = a; data_in = d;
        if (push) begin
            t = e;
            t.issue = cyc;
            q.push_back(t);
            n_exp++;
        end
        @(posedge clk); #1;
        cs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Monitor: accumulates pin activity between rdy pulses, compares on each rdy.
    logic [5:0] a_cs_low, a_rst_low;
    int         a_cs_n, a_rst_n, a_busy, a_strb_first, a_strb_len;

    task automatic clear_acc();
        a_cs_low = '0; a_rst_low = '0;
        a_cs_n = 0; a_rst_n = 0; a_busy = 0; a_strb_first = 0; a_strb_len = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            clear_acc();
        end else begin
            if (busy) a_busy++;
            if (CS_N != 6'h3F) begin a_cs_low |= ~CS_N; a_cs_n++; end
            if (RESET_N != 6'h3F) begin a_rst_low |= ~RESET_N; a_rst_n++; end
            if (!STROBE) begin
                if (a_strb_len == 0) a_strb_first = cyc;
                a_strb_len++;
            end
            if (rdy) begin
                n_rdy++;
                if (q.size() == 0) begin
                    n_extra++;
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.issue, e.lat);
                    chk("err", err, e.err);
                    chk("busy_cycles", a_busy, e.busy_n);
                    chk("cs_n_low_mask", a_cs_low, e.cs_low);
                    chk("cs_n_low_cycles", a_cs_n, e.cs_n);
                    chk("cs_n_at_rdy", CS_N, 6'h3F);
                    chk("reset_n_low_mask", a_rst_low, e.rst_low);
                    chk("reset_n_low_cycles", a_rst_n, e.rst_n);
                    chk("strobe_first", (a_strb_len != 0) ? a_strb_first - e.issue : 0, e.strb_first);
                    chk("strobe_len", a_strb_len, e.strb_len);
                    chk("ax", AX, e.ax);
                    chk("ay", AY, e.ay);
                    chk("data", DATA, e.data);
                end
                clear_acc();
            end
        end
    end

    // Fast-timing instances: N_CHIP=1 and N_CHIP=16, all write phases one cycle.
    task automatic sweep(input logic [3:0] o, input logic [15:0] d,
                         input logic rej1, input logic [15:0] csn16);
        @(posedge clk); #1;
        cs2 = 1'b1; op = o; addr = 8'h21; data_in = d;
        @(posedge clk); #1;
        cs2 = 1'b0;
        @(negedge clk); // cycle 1
        chk("n16_cs_n_c1", CS_N16, csn16);
        chk("n1_cs_n_c1", CS_N1, rej1 ? 1 : 0);
        chk("n1_rdy_c1", rdy1, rej1);
        chk("n1_err_c1", err1, rej1);
        chk("n16_rdy_c1", rdy16, 0);
        @(negedge clk); // cycle 2
        chk("n16_strobe_c2", STROBE16, 0);
        @(negedge clk); // cycle 3
        chk("n16_rdy_c3", rdy16, 0);
        @(negedge clk); // cycle 4
        chk("n16_rdy_c4", rdy16, 1);
        chk("n16_cs_n_c4", CS_N16, 16'hFFFF);
        chk("n1_rdy_c4", rdy1, rej1 ? 0 : 1);
    endtask

    exp_t dummy;

    initial begin
        rst = 1'b1; cs = 1'b0; cs2 = 1'b0; op = '0; addr = '0; data_in = '0;
        last_ax = '0; last_ay = '0; last_data = 1'b0;
        dummy = exp_reject();
        clear_acc();
        idle(3);
        @(negedge clk);
        chk("rst_cs_n", CS_N, 6'h3F);
        chk("rst_reset_n", RESET_N, 6'h3F);
        chk("rst_strobe", STROBE, 1);
        chk("rst_data", DATA, 0);
        chk("rst_ax", AX, 0);
        chk("rst_ay", AY, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(4'd1, 8'h35, 16'h0002, 1'b1, exp_write(6'b000100, 4'h5, 3'd3, 1'b1)); idle(12);
        send(4'd5, 8'hA7, 16'h0029, 1'b1, exp_write(6'b101001, 4'h7, 3'd2, 1'b0)); idle(12);
        send(4'd3, 8'hFF, 16'h003F, 1'b1, exp_reset(6'h3F));                       idle(12);
        send(4'd1, 8'h35, 16'h0006, 1'b1, exp_reject());                           idle(4);
        send(4'd4, 8'h35, 16'h0040, 1'b1, exp_reject());                           idle(4);
        send(4'd7, 8'h35, 16'h003F, 1'b1, exp_reject());                           idle(4);
        send(4'd4, 8'h4C, 16'hFF11, 1'b1, exp_write(6'b010001, 4'hC, 3'd4, 1'b1)); idle(12);
        send(4'd2, 8'h00, 16'h0005, 1'b1, exp_write(6'b100000, 4'h0, 3'd0, 1'b0)); idle(12);
        send(4'd0, 8'h35, 16'h0001, 1'b1, exp_reject());                           idle(4);

        // cs during STRB (cycle 3) and during DONE (cycle 9) must be dropped.
        send(4'd1, 8'h12, 16'h0000, 1'b1, exp_write(6'b000001, 4'h2, 3'd1, 1'b1));
        idle(1);
        send(4'd3, 8'h00, 16'h003F, 1'b0, dummy);
        idle(4);
        send(4'd1, 8'h00, 16'h0001, 1'b0, dummy);
        idle(8);

        // rst while STROBE is low.
        send(4'd1, 8'h5A, 16'h0004, 1'b0, dummy);
        idle(2);
        @(negedge clk);
        chk("strobe_before_rst", STROBE, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cs_n", CS_N, 6'h3F);
        chk("midrst_reset_n", RESET_N, 6'h3F);
        chk("midrst_strobe", STROBE, 1);
        chk("midrst_data", DATA, 0);
        chk("midrst_ax", AX, 0);
        chk("midrst_ay", AY, 0);
        chk("midrst_rdy", rdy, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_state", int'(dut.state), int'(ST_IDLE));
        last_ax = '0; last_ay = '0; last_data = 1'b0;

        send(4'd1, 8'h7F, 16'h0003, 1'b1, exp_write(6'b001000, 4'hF, 3'd7, 1'b1)); idle(12);

        sweep(4'd1, 16'h0000, 1'b0, 16'hFFFE);
        idle(4);
        sweep(4'd4, 16'h8000, 1'b1, 16'h7FFF);
        idle(4);

        chk("pending_rdy", q.size(), 0);
        chk("extra_rdy", n_extra, 0);
        chk("rdy_count", n_rdy, n_exp);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
